// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between instruction fetch (I) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    input  logic              i_resp_ready,
    output logic [31:0]       i_resp_rdata,
    output logic              i_resp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    input  logic [2:0]        d_req_load_type,
    input  logic [2:0]        d_req_store_type,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [31:0]       d_resp_rdata,
    output logic              d_resp_err,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [2:0]        mem_load_type,
    output logic [2:0]        mem_store_type,
    input  logic [31:0]       mem_data_out,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_lt_q, mem_lt_d;
    logic [2:0]        mem_st_q, mem_st_d;

    logic d_wins;
    logic d_accept, i_accept;
    logic d_bad, i_bad;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On contention the port that did not win last time goes first
    always_comb begin
        if (d_req_valid && i_req_valid) begin
            d_wins = (last_grant_q == PORT_I);
        end else begin
            d_wins = d_req_valid;
        end
    end
`else
    assign d_wins = d_req_valid;
`endif

    assign d_accept = rst_n && (state_q == IDLE) && d_req_valid && d_wins;
    assign i_accept = rst_n && (state_q == IDLE) && i_req_valid && !d_wins;

    assign i_bad = |i_req_addr[1:0];

    always_comb begin
        d_bad = 1'b0;
        if (d_req_we) begin
            case (d_req_store_type)
                3'b000:  d_bad = 1'b0;
                3'b001:  d_bad = d_req_addr[0];
                3'b010:  d_bad = |d_req_addr[1:0];
                default: d_bad = 1'b1;
            endcase
        end else begin
            case (d_req_load_type)
                3'b000, 3'b100: d_bad = 1'b0;
                3'b001, 3'b101: d_bad = d_req_addr[0];
                3'b010:         d_bad = |d_req_addr[1:0];
                default:        d_bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_lt_d    = mem_lt_q;
        mem_st_d    = mem_st_q;
        case (state_q)
            IDLE: begin
                // Rejected requests never touch the mem_* registers
                if (d_accept) begin
                    port_d  = PORT_D;
                    we_d    = d_req_we;
                    err_d   = d_bad;
                    rdata_d = '0;
                    state_d = d_bad ? RESP : ISSUE;
                    if (!d_bad) begin
                        mem_addr_d  = d_req_addr;
                        mem_wdata_d = d_req_wdata;
                        mem_lt_d    = d_req_load_type;
                        mem_st_d    = d_req_store_type;
                    end
                end else if (i_accept) begin
                    port_d  = PORT_I;
                    we_d    = 1'b0;
                    err_d   = i_bad;
                    rdata_d = '0;
                    state_d = i_bad ? RESP : ISSUE;
                    if (!i_bad) begin
                        mem_addr_d = i_req_addr;
                        mem_lt_d   = 3'b010;
                    end
                end
            end
            ISSUE:     state_d = we_q ? RESP : WAIT_DATA;
            WAIT_DATA: begin
                rdata_d = mem_data_out;
                state_d = RESP;
            end
            RESP: begin
                if ((port_q == PORT_D) ? d_resp_ready : i_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (d_accept) begin
            last_grant_d = PORT_D;
        end else if (i_accept) begin
            last_grant_d = PORT_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= PORT_I;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_lt_q    <= '0;
            mem_st_q    <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_lt_q    <= mem_lt_d;
            mem_st_q    <= mem_st_d;
        end
    end

    assign d_req_ready    = d_accept;
    assign i_req_ready    = i_accept;
    assign d_resp_valid   = (state_q == RESP) && (port_q == PORT_D);
    assign i_resp_valid   = (state_q == RESP) && (port_q == PORT_I);
    assign d_resp_rdata   = rdata_q;
    assign i_resp_rdata   = rdata_q;
    assign d_resp_err     = err_q;
    assign i_resp_err     = err_q;
    assign mem_read_en    = (state_q == ISSUE) && !we_q;
    assign mem_write_en   = (state_q == ISSUE) && we_q;
    assign mem_address    = mem_addr_q;
    assign mem_data_in    = mem_wdata_q;
    assign mem_load_type  = mem_lt_q;
    assign mem_store_type = mem_st_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory, transaction-level reference model checked every
// cycle, and directed transactions with literal expectations.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req_valid = 1'b0, i_req_ready;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic              i_resp_valid, i_resp_ready = 1'b1, i_resp_err;
    logic [31:0]       i_resp_rdata;
    logic              d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0;
    logic [ADDR_W-1:0] d_req_addr = '0;
    logic [31:0]       d_req_wdata = '0;
    logic [2:0]        d_req_load_type = '0, d_req_store_type = '0;
    logic              d_resp_valid, d_resp_ready = 1'b1, d_resp_err;
    logic [31:0]       d_resp_rdata;
    logic              mem_read_en, mem_write_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in, mem_data_out;
    logic [2:0]        mem_load_type, mem_store_type;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_load_type(d_req_load_type), .d_req_store_type(d_req_store_type),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_load_type(mem_load_type),
        .mem_store_type(mem_store_type), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [142:0] all_outs;
    assign all_outs = {i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err, d_req_ready,
                       d_resp_valid, d_resp_rdata, d_resp_err, mem_read_en, mem_write_en,
                       mem_address, mem_data_in, mem_load_type, mem_store_type, busy};

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    function automatic logic [31:0] ld_fmt(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [2:0] t);
        case (t)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic bit bad_req(input bit we, input logic [1:0] a,
                                   input logic [2:0] lt, input logic [2:0] st);
        if (we) begin
            if (st == 3'b000) return 1'b0;
            if (st == 3'b001) return a[0];
            if (st == 3'b010) return a != 2'b00;
            return 1'b1;
        end
        if (lt == 3'b000 || lt == 3'b100) return 1'b0;
        if (lt == 3'b001 || lt == 3'b101) return a[0];
        if (lt == 3'b010) return a != 2'b00;
        return 1'b1;
    endfunction

    // Memory seen by the DUT: registered read, little-endian byte lanes
    logic [7:0] bmem [256];
    logic [7:0] rmem [256];

    always @(posedge clk) begin
        if (mem_write_en) begin
            bmem[mem_address[7:0]] <= mem_data_in[7:0];
            if (mem_store_type != 3'b000) bmem[8'(mem_address[7:0] + 8'd1)] <= mem_data_in[15:8];
            if (mem_store_type == 3'b010) begin
                bmem[8'(mem_address[7:0] + 8'd2)] <= mem_data_in[23:16];
                bmem[8'(mem_address[7:0] + 8'd3)] <= mem_data_in[31:24];
            end
        end
        if (mem_read_en) begin
            mem_data_out <= ld_fmt(bmem[mem_address[7:0]], bmem[8'(mem_address[7:0] + 8'd1)],
                                   bmem[8'(mem_address[7:0] + 8'd2)],
                                   bmem[8'(mem_address[7:0] + 8'd3)], mem_load_type);
        end
    end

    task automatic ref_store(input logic [2:0] st, input logic [7:0] a, input logic [31:0] d);
        rmem[a] = d[7:0];
        if (st != 3'b000) rmem[8'(a + 8'd1)] = d[15:8];
        if (st == 3'b010) begin
            rmem[8'(a + 8'd2)] = d[23:16];
            rmem[8'(a + 8'd3)] = d[31:24];
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: m_k counts cycles since the accept edge; kind 0=error, 1=load, 2=store
    bit          m_busy = 1'b0, m_port = 1'b0, m_last = 1'b0, m_err = 1'b0;
    int          m_kind = 0, m_k = 0, m_lat = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [2:0]  m_lt = '0, m_st = '0;
    int          acc_cyc = 0, last_lat = 0, en_cnt = 0;
    bit          seen = 1'b0, last_port = 1'b0, last_err = 1'b0;
    logic [31:0] last_rdata = '0;
    bit          glog[$];

    always @(negedge clk) begin
        bit ed, ei, eresp;
        if (!rst_n) begin
            chk1("reset_outputs", |all_outs, 1'b0);
            m_busy = 1'b0;
            m_last = 1'b0;
        end else begin
            ed = 1'b0;
            ei = 1'b0;
            if (!m_busy) begin
`ifdef MEM_ARB_RR_EN
                if (d_req_valid && i_req_valid) begin
                    ed = (m_last == 1'b0);
                    ei = !ed;
                end else begin
                    ed = d_req_valid;
                    ei = i_req_valid;
                end
`else
                ed = d_req_valid;
                ei = i_req_valid && !d_req_valid;
`endif
            end
            m_lat = (m_kind == 0) ? 1 : (m_kind == 1) ? 3 : 2;
            eresp = m_busy && (m_k >= m_lat);
            chk1("d_req_ready", d_req_ready, ed);
            chk1("i_req_ready", i_req_ready, ei);
            chk1("busy", busy, m_busy);
            chk1("mem_read_en", mem_read_en, m_busy && m_k == 1 && m_kind == 1);
            chk1("mem_write_en", mem_write_en, m_busy && m_k == 1 && m_kind == 2);
            if (m_busy && m_k == 1 && m_kind != 0) begin
                chk("mem_address", mem_address, m_addr);
                if (m_kind == 2) begin
                    chk("mem_data_in", mem_data_in, m_wdata);
                    chk("mem_store_type", 32'(mem_store_type), 32'(m_st));
                end else begin
                    chk("mem_load_type", 32'(mem_load_type), 32'(m_lt));
                end
            end
            chk1("d_resp_valid", d_resp_valid, eresp && m_port);
            chk1("i_resp_valid", i_resp_valid, eresp && !m_port);
            if (eresp) begin
                chk("resp_rdata", m_port ? d_resp_rdata : i_resp_rdata, m_rdata);
                chk1("resp_err", m_port ? d_resp_err : i_resp_err, m_err);
            end

            // Observed behaviour, compared against literals by the directed sequence
            if (mem_read_en || mem_write_en) en_cnt++;
            if ((d_resp_valid || i_resp_valid) && !seen) begin
                seen       = 1'b1;
                last_lat   = cyc - acc_cyc;
                last_port  = d_resp_valid;
                last_rdata = d_resp_valid ? d_resp_rdata : i_resp_rdata;
                last_err   = d_resp_valid ? d_resp_err : i_resp_err;
            end
            if (d_req_ready || i_req_ready) begin
                glog.push_back(d_req_ready);
                acc_cyc = cyc;
                seen    = 1'b0;
                en_cnt  = 0;
            end

            if (m_busy) begin
                if (eresp && (m_port ? d_resp_ready : i_resp_ready)) m_busy = 1'b0;
                else m_k++;
            end else if (ed || ei) begin
                m_port = ed;
                m_last = ed;
                m_busy = 1'b1;
                m_k    = 1;
                if (ed) begin
                    m_addr  = d_req_addr;
                    m_wdata = d_req_wdata;
                    m_lt    = d_req_load_type;
                    m_st    = d_req_store_type;
                    m_err   = bad_req(d_req_we, d_req_addr[1:0], m_lt, m_st);
                    m_kind  = m_err ? 0 : (d_req_we ? 2 : 1);
                end else begin
                    m_addr = i_req_addr;
                    m_lt   = 3'b010;
                    m_err  = (i_req_addr[1:0] != 2'b00);
                    m_kind = m_err ? 0 : 1;
                end
                m_rdata = '0;
                if (m_kind == 2) begin
                    ref_store(m_st, m_addr[7:0], m_wdata);
                end else if (m_kind == 1) begin
                    m_rdata = ld_fmt(rmem[m_addr[7:0]], rmem[8'(m_addr[7:0] + 8'd1)],
                                     rmem[8'(m_addr[7:0] + 8'd2)],
                                     rmem[8'(m_addr[7:0] + 8'd3)], m_lt);
                end
            end
        end
    end

    task automatic wait_accept(input bit port);
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (port ? d_req_ready : i_req_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        chk1("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk1("idle_timeout", ok, 1'b1);
    endtask

    task automatic d_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] lt, input logic [2:0] st);
        @(posedge clk);
        #1;
        d_req_we = we;
        d_req_addr = addr;
        d_req_wdata = wdata;
        d_req_load_type = lt;
        d_req_store_type = st;
        d_req_valid = 1'b1;
        wait_accept(1'b1);
        d_req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic i_fetch(input logic [31:0] addr);
        @(posedge clk);
        #1;
        i_req_addr = addr;
        i_req_valid = 1'b1;
        wait_accept(1'b0);
        i_req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic expect_last(input string tag, input bit port, input logic [31:0] rdata,
                               input bit err, input int lat, input int en);
        chk1({tag, "_port"}, last_port, port);
        chk({tag, "_rdata"}, last_rdata, rdata);
        chk1({tag, "_err"}, last_err, err);
        chk({tag, "_latency"}, 32'(last_lat), 32'(lat));
        chk({tag, "_enables"}, 32'(en_cnt), 32'(en));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        int         cnt;
        bit         flag;
        for (int i = 0; i < 256; i++) begin
            bmem[i] <= 8'h00;
            rmem[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_reset_busy", busy, 1'b0);

        // Word store then load back
        d_op(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 3'b010);
        expect_last("sw", 1'b1, 32'h0, 1'b0, 2, 1);
        d_op(1'b0, 32'h10, 32'h0, 3'b010, 3'b000);
        expect_last("lw", 1'b1, 32'hDEADBEEF, 1'b0, 3, 1);

        // Byte store, signed/unsigned byte loads, signed half load (bytes 0x12=AD, 0x13=80)
        d_op(1'b1, 32'h13, 32'h00000080, 3'b000, 3'b000);
        expect_last("sb", 1'b1, 32'h0, 1'b0, 2, 1);
        d_op(1'b0, 32'h13, 32'h0, 3'b000, 3'b000);
        expect_last("lb", 1'b1, 32'hFFFFFF80, 1'b0, 3, 1);
        d_op(1'b0, 32'h13, 32'h0, 3'b100, 3'b000);
        expect_last("lbu", 1'b1, 32'h00000080, 1'b0, 3, 1);
        d_op(1'b0, 32'h12, 32'h0, 3'b001, 3'b000);
        expect_last("lh", 1'b1, 32'hFFFF80AD, 1'b0, 3, 1);

        // Rejected accesses never reach memory
        d_op(1'b0, 32'h02, 32'h0, 3'b010, 3'b000);
        expect_last("lw_misaligned", 1'b1, 32'h0, 1'b1, 1, 0);
        d_op(1'b1, 32'h21, 32'h12345678, 3'b000, 3'b001);
        expect_last("sh_misaligned", 1'b1, 32'h0, 1'b1, 1, 0);
        d_op(1'b0, 32'h00, 32'h0, 3'b011, 3'b000);
        expect_last("bad_load_type", 1'b1, 32'h0, 1'b1, 1, 0);
        d_op(1'b1, 32'h00, 32'h0, 3'b000, 3'b101);
        expect_last("bad_store_type", 1'b1, 32'h0, 1'b1, 1, 0);

        // Fetches (the last grant is I before the contention test)
        i_fetch(32'h11);
        expect_last("fetch_misaligned", 1'b0, 32'h0, 1'b1, 1, 0);
        i_fetch(32'h10);
        expect_last("fetch", 1'b0, 32'h80ADBEEF, 1'b0, 3, 1);

        // Both ports held valid for four grants
        glog.delete();
        @(posedge clk);
        #1;
        d_req_we = 1'b0;
        d_req_addr = 32'h10;
        d_req_load_type = 3'b010;
        d_req_valid = 1'b1;
        i_req_addr = 32'h10;
        i_req_valid = 1'b1;
        cnt = 0;
        for (int n = 0; n < 100 && cnt < 4; n++) begin
            @(negedge clk);
            if (d_req_ready || i_req_ready) cnt++;
        end
        if (cnt == 4) begin
            @(posedge clk);
            #1;
        end
        d_req_valid = 1'b0;
        i_req_valid = 1'b0;
        wait_idle();
`ifdef MEM_ARB_RR_EN
        exp_g = 4'b0101;
`else
        exp_g = 4'b1111;
`endif
        chk("grant_count", 32'(glog.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) chk1($sformatf("grant_%0d_is_d", k), glog[k], exp_g[k]);
        end

        // Response back-pressure with a fetch waiting
        d_resp_ready = 1'b0;
        @(posedge clk);
        #1;
        d_req_we = 1'b0;
        d_req_addr = 32'h10;
        d_req_load_type = 3'b010;
        d_req_valid = 1'b1;
        wait_accept(1'b1);
        d_req_valid = 1'b0;
        i_req_addr = 32'h10;
        i_req_valid = 1'b1;
        flag = 1'b0;
        for (int n = 0; n < 10 && !flag; n++) begin
            @(negedge clk);
            if (d_resp_valid) flag = 1'b1;
        end
        chk1("bp_resp_seen", flag, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk1("bp_resp_valid", d_resp_valid, 1'b1);
            chk("bp_resp_rdata", d_resp_rdata, 32'h80ADBEEF);
            chk1("bp_busy", busy, 1'b1);
            chk1("bp_i_req_ready", i_req_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        d_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("bp_release_idle", busy, 1'b0);
        chk1("bp_release_i_ready", i_req_ready, 1'b1);
        chk1("bp_release_resp_low", d_resp_valid, 1'b0);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        wait_idle();
        expect_last("bp_fetch", 1'b0, 32'h80ADBEEF, 1'b0, 3, 1);

        // Reset while waiting for read data
        @(posedge clk);
        #1;
        d_req_we = 1'b0;
        d_req_addr = 32'h10;
        d_req_load_type = 3'b010;
        d_req_valid = 1'b1;
        wait_accept(1'b1);
        d_req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_reset_outputs", |all_outs, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk1("no_resp_after_reset", d_resp_valid || i_resp_valid, 1'b0);
        end
        i_fetch(32'h10);
        expect_last("fetch_after_reset", 1'b0, 32'h80ADBEEF, 1'b0, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-port data memory and shares it between two requesters: instruction fetch (I port) and load/store unit (D port).
- The memory it drives has one-cycle registered read data and accepts load/store type codes.
- Arbitrates, issues exactly one memory enable pulse per transaction, captures read data, and returns a held response to the winning requester.
- Rejects misaligned or unsupported accesses with an error response, without touching memory.

Parameters:
ADDR_W, 32, width of request and memory addresses

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_W  fetch address; always a word load
i_resp_valid  out  1  fetch response valid
i_resp_ready  in  1  fetch response consumed
i_resp_rdata  out  32  fetched word
i_resp_err  out  1  misaligned fetch
d_req_valid  in  1  load/store request valid
d_req_ready  out  1  load/store request accepted
d_req_we  in  1  1 = store, 0 = load
d_req_addr  in  ADDR_W  byte address
d_req_wdata  in  32  store data
d_req_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
d_req_store_type  in  3  000 SB, 001 SH, 010 SW
d_resp_valid  out  1  load/store response valid
d_resp_ready  in  1  load/store response consumed
d_resp_rdata  out  32  load result; 0 for stores
d_resp_err  out  1  misaligned or unsupported type
mem_read_en  out  1  memory read pulse
mem_write_en  out  1  memory write pulse
mem_address  out  ADDR_W  memory address
mem_data_in  out  32  memory write data
mem_load_type  out  3  memory load type
mem_store_type  out  3  memory store type
mem_data_out  in  32  memory read data, valid the cycle after mem_read_en
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - All outputs 0.
  - Latched request cleared.
  - last_grant = I.
- States: IDLE, ISSUE, WAIT_DATA, RESP.
- IDLE:
  - Selects a winner. Fixed priority: D over I.
  - Winner's req_ready is combinationally 1 while valid; the loser's is 0.
  - req_ready is 0 in every other state.
  - On handshake, latch port ID, address, we, wdata and type. I port type forced to load 010.
- Error check at acceptance:
  - Word access with addr[1:0] != 0: error.
  - Half access with addr[0] != 0: error.
  - Load types 011/110/111 or store types 011..111: error.
  - On error, go directly to RESP with err = 1, rdata = 0. No memory enable is ever asserted.
- ISSUE:
  - Exactly one cycle of mem_read_en (load) or mem_write_en (store), with latched address, data and types on mem_*.
  - mem_* data/type outputs hold their values outside ISSUE; enables are 0 outside ISSUE.
  - Load goes to WAIT_DATA. Store goes to RESP.
- WAIT_DATA: capture mem_data_out into the response data register, then go to RESP.
- RESP:
  - Granted port's resp_valid = 1, with rdata and err held stable until resp_ready is sampled 1.
  - Then go to IDLE. resp_valid falls the next cycle.
  - The other port's resp_valid stays 0.
- Latency from accept edge:
  - Load: resp_valid at cycle 3.
  - Store: resp_valid at cycle 2.
  - Error: resp_valid at cycle 1.
  - Minimum back-to-back spacing: load 4 cycles, store 3 cycles.
- One transaction outstanding at a time. No new accept until return to IDLE.
- Simultaneous valid on both ports in IDLE: arbitration policy decides the winner. The loser waits with valid held, and is served next if still valid.
- Requests that drop valid before handshake are ignored and not latched.
- Reset mid-transaction aborts immediately and no response is produced. An in-flight store may or may not have reached memory.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. On a simultaneous request, grant the port other than last_grant. last_grant updates on every handshake. After reset, the first contention goes to D.
- Undefined: fixed priority, D over I. last_grant is not implemented.

Test Plan:
1. Single D store SW, addr 0x10, data 0xDEADBEEF, then LW 0x10:
   - Store: mem_write_en for exactly one cycle, d_resp_valid at cycle 2, err 0.
   - Load: d_resp_rdata 0xDEADBEEF at cycle 3.
2. SB 0x80 to 0x13, then LB 0x13 and LBU 0x13:
   - LB returns 0xFFFFFF80.
   - LBU returns 0x00000080.
3. Misaligned LW at 0x02 and SH at 0x21:
   - d_resp_err 1, rdata 0, resp at cycle 1.
   - mem_read_en/mem_write_en never asserted.
4. i_req_valid and d_req_valid asserted together in IDLE and held for 4 transactions:
   - Fixed priority: D wins every time while it stays valid.
   - With MEM_ARB_RR_EN: grants D, I, D, I.
5. Response back-pressure: hold d_resp_ready 0 for 5 cycles:
   - resp_valid and rdata stay stable, busy 1, i_req_ready 0 throughout.
   - Release: IDLE next cycle.
6. rst_n low during WAIT_DATA:
   - All outputs 0 asynchronously.
   - No response after release.
   - A new I fetch completes normally.
